// File: rtl/sram_bus_bridge.sv
// sram_bus_bridge: validates byte/half/word host requests and issues lane-aligned single-cycle SRAM accesses
module sram_bus_bridge #(
  parameter int ADDR_W      = 13,
  parameter int DEPTH_BYTES = 8192,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic                 sram_req,
  output logic                 sram_we,
  output logic [3:0]           sram_be,
  output logic [ADDR_W-1:0]    sram_addr,
  output logic [31:0]          sram_wdata,
  input  logic [31:0]          sram_rdata,
  input  logic                 sram_ready,
  input  logic                 mbist_en,
  input  logic                 ret_en,
  input  logic                 pd_en,
  output logic [ERR_CNT_W-1:0] err_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH_BYTES);
  state_t st, st_nx;
  logic wr;
  logic [1:0] sz;
  logic [ADDR_W-1:0] addr;
  logic [31:0] wdata, sh, rdata_nx, wd;
  logic [3:0] be;
  logic blocked, req_bad, issue, err_set;
  assign blocked = mbist_en | ret_en | !pd_en;
  assign req_bad = (req_size == 2'd3) | (req_size == 2'd1 & req_addr[0]) |
                   (req_size == 2'd2 & req_addr[1:0] != 2'd0) |
                   ({1'b0, req_addr} >= DEPTH_L) | blocked;
  assign issue   = st == ISSUE;
  assign err_set = (st == IDLE & req_valid & req_bad) | (issue & blocked);
  assign sh       = sram_rdata >> {addr[1:0], 3'b000};
  assign rdata_nx = sz == 2'd0 ? {24'd0, sh[7:0]} : sz == 2'd1 ? {16'd0, sh[15:0]} : sh;
  assign be = sz == 2'd0 ? 4'b0001 << addr[1:0] : sz == 2'd1 ? 4'b0011 << addr[1:0] : 4'b1111;
  assign wd = sz == 2'd0 ? {4{wdata[7:0]}} : sz == 2'd1 ? {2{wdata[15:0]}} : wdata;
  assign req_ready  = st == IDLE;
  assign rsp_valid  = st == RESP;
  assign sram_req   = issue & !blocked;
  assign sram_we    = issue & wr;
  assign sram_be    = issue ? be : 4'd0;
  assign sram_addr  = issue ? {addr[ADDR_W-1:2], 2'b00} : '0;
  assign sram_wdata = issue ? wd : 32'd0;
  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:    st_nx = req_valid ? (req_bad ? RESP : ISSUE) : IDLE;
      ISSUE:   st_nx = blocked ? RESP : sram_ready ? (wr ? RESP : CAPTURE) : ISSUE;
      CAPTURE: st_nx = RESP;
      RESP:    st_nx = rsp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      wr        <= 1'b0;
      sz        <= 2'd0;
      addr      <= '0;
      wdata     <= 32'd0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'd0;
      err_count <= '0;
    end else begin
      st <= st_nx;
      if (st == IDLE && req_valid) begin
        wr        <= req_write;
        sz        <= req_size;
        addr      <= req_addr;
        wdata     <= req_wdata;
        rsp_err   <= req_bad;
        rsp_rdata <= 32'd0;
      end
      if (issue && blocked) rsp_err <= 1'b1;
      if (st == CAPTURE) rsp_rdata <= rdata_nx;
      if (err_set && !(&err_count)) err_count <= err_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_sram_bus_bridge.sv
// tb_sram_bus_bridge: randomized and directed checks of sram_bus_bridge against a byte-array reference model
module tb_sram_bus_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [1:0] req_size = 2'd0;
  logic [12:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0] rsp_rdata;
  logic sram_req, sram_we, sram_ready = 1'b1;
  logic [3:0] sram_be;
  logic [12:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic mbist_en = 1'b0, ret_en = 1'b0, pd_en = 1'b1;
  logic [7:0] err_count;

  sram_bus_bridge #(.ADDR_W(13), .DEPTH_BYTES(4096), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sram_req(sram_req), .sram_we(sram_we), .sram_be(sram_be), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready),
    .mbist_en(mbist_en), .ret_en(ret_en), .pd_en(pd_en), .err_count(err_count));

  always #5 clk = ~clk;

  // Simple SRAM behind the controller: data appears the cycle after a sampled read strobe
  logic [31:0] mem [0:2047];
  always @(posedge clk) if (sram_req && sram_ready) begin
    for (int i = 0; i < 4; i++)
      if (sram_we && sram_be[i]) mem[sram_addr[12:2]][8*i +: 8] <= sram_wdata[8*i +: 8];
    sram_rdata <= mem[sram_addr[12:2]];
  end

  int strobes = 0;
  logic [3:0] mon_be;
  logic [31:0] mon_wdata;
  logic [12:0] mon_addr;
  always @(posedge clk) if (sram_req) begin
    strobes   <= strobes + 1;
    mon_be    <= sram_be;
    mon_wdata <= sram_wdata;
    mon_addr  <= sram_addr;
  end

  int checks = 0, errors = 0;
  logic [7:0] ref_mem [0:4095];
  logic [7:0] exp_cnt = 8'd0;

  function automatic int nbytes(input logic [1:0] s);
    return s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
  endfunction

  function automatic void model(input logic w, input logic [1:0] s, input logic [12:0] a,
                                input logic [31:0] d, input logic blk,
                                output logic e, output logic [31:0] r);
    int n = nbytes(s);
    e = (s == 2'd3) || (int'(a) % n != 0) || (int'(a) >= 4096) || blk;
    r = 32'd0;
    if (!e)
      for (int i = 0; i < n; i++)
        if (w) ref_mem[int'(a) + i] = d[8*i +: 8];
        else r[8*i +: 8] = ref_mem[int'(a) + i];
    if (e && exp_cnt != 8'hFF) exp_cnt++;
  endfunction

  task automatic xact(input logic w, input logic [1:0] s, input logic [12:0] a, input logic [31:0] d,
                      input int stall, output logic e, output logic [31:0] r, output int lat, output int nstr);
    int s0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = s; req_addr = a; req_wdata = d;
    s0 = strobes;
    @(posedge clk); #1;
    req_valid = 1'b0;
    sram_ready = (stall == 0);
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      sram_ready = (lat >= stall);
    end
    sram_ready = 1'b1;
    if (!rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: rsp_valid=%0b after %0d cycles, required 1", rsp_valid, lat);
    end
    e = rsp_err; r = rsp_rdata; nstr = strobes - s0;
    if (rsp_ready) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++; if ({rsp_valid, rsp_err} !== 2'b00) begin errors++; $display("FAIL reset_rsp: got %b want 00", {rsp_valid, rsp_err}); end
    checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
    checks++; if ({sram_req, sram_we, sram_be} !== 6'd0) begin errors++; $display("FAIL reset_sram: got %b want 0", {sram_req, sram_we, sram_be}); end
  endtask

  task automatic test_fill;
    logic e, ee; logic [31:0] r, er, d; int lat, ns;
    for (int a = 0; a < 'h200; a += 4) begin
      d = $urandom;
      model(1'b1, 2'd2, 13'(a), d, 1'b0, ee, er);
      xact(1'b1, 2'd2, 13'(a), d, 0, e, r, lat, ns);
      checks++; if (e !== 1'b0 || lat != 1) begin errors++; $display("FAIL fill_write @%h: err=%b lat=%0d want err=0 lat=1", a, e, lat); end
    end
  endtask

  task automatic test_word_rw;
    logic e, ee; logic [31:0] r, er; int lat, ns;
    model(1'b1, 2'd2, 13'h0, 32'hDEADBEEF, 1'b0, ee, er);
    xact(1'b1, 2'd2, 13'h0, 32'hDEADBEEF, 0, e, r, lat, ns);
    checks++; if (e !== 1'b0 || lat != 1) begin errors++; $display("FAIL word_write: err=%b lat=%0d want 0/1", e, lat); end
    model(1'b0, 2'd2, 13'h0, 32'h0, 1'b0, ee, er);
    xact(1'b0, 2'd2, 13'h0, 32'h0, 0, e, r, lat, ns);
    checks++; if (r !== 32'hDEADBEEF || er !== 32'hDEADBEEF) begin errors++; $display("FAIL word_read_data: got %h want DEADBEEF", r); end
    checks++; if (e !== 1'b0 || lat != 2) begin errors++; $display("FAIL word_read_lat: err=%b lat=%0d want 0/2", e, lat); end
  endtask

  task automatic test_byte_lanes;
    logic e, ee; logic [31:0] r, er; int lat, ns;
    model(1'b1, 2'd0, 13'h101, 32'h000000AA, 1'b0, ee, er);
    xact(1'b1, 2'd0, 13'h101, 32'h000000AA, 0, e, r, lat, ns);
    checks++; if (mon_be !== 4'b0010) begin errors++; $display("FAIL byte_be: got %b want 0010", mon_be); end
    checks++; if (mon_wdata !== 32'hAAAAAAAA) begin errors++; $display("FAIL byte_wdata: got %h want AAAAAAAA", mon_wdata); end
    checks++; if (mon_addr !== 13'h100) begin errors++; $display("FAIL byte_addr: got %h want 0100", mon_addr); end
    model(1'b0, 2'd0, 13'h101, 32'h0, 1'b0, ee, er);
    xact(1'b0, 2'd0, 13'h101, 32'h0, 0, e, r, lat, ns);
    checks++; if (r !== 32'h000000AA) begin errors++; $display("FAIL byte_read: got %h want 000000AA", r); end
    model(1'b1, 2'd1, 13'h102, 32'hFFFF1234, 1'b0, ee, er);
    xact(1'b1, 2'd1, 13'h102, 32'hFFFF1234, 0, e, r, lat, ns);
    checks++; if (mon_be !== 4'b1100 || mon_wdata !== 32'h12341234) begin errors++; $display("FAIL half_lanes: be=%b wdata=%h want 1100/12341234", mon_be, mon_wdata); end
    model(1'b0, 2'd2, 13'h100, 32'h0, 1'b0, ee, er);
    xact(1'b0, 2'd2, 13'h100, 32'h0, 0, e, r, lat, ns);
    checks++; if (r !== er) begin errors++; $display("FAIL merged_word: got %h want %h", r, er); end
    @(negedge clk);
    checks++; if (sram_addr !== 13'd0 || sram_wdata !== 32'd0 || sram_be !== 4'd0) begin errors++; $display("FAIL idle_sram_zero: addr=%h wdata=%h be=%b want 0", sram_addr, sram_wdata, sram_be); end
  endtask

  task automatic test_errors;
    logic e, ee; logic [31:0] r, er; int lat, ns;
    logic [1:0] sz [4] = '{2'd1, 2'd2, 2'd3, 2'd2};
    logic [12:0] ad [4] = '{13'h203, 13'h102, 13'h010, 13'h1000};
    for (int k = 0; k < 4; k++) begin
      model(k[0], sz[k], ad[k], 32'h55AA55AA, 1'b0, ee, er);
      xact(k[0], sz[k], ad[k], 32'h55AA55AA, 0, e, r, lat, ns);
      checks++; if (e !== 1'b1 || ns != 0 || lat != 0 || r !== 32'd0) begin errors++; $display("FAIL error_req%0d: err=%b strobes=%0d lat=%0d rdata=%h want 1/0/0/0", k, e, ns, lat, r); end
    end
    checks++; if (err_count !== exp_cnt || exp_cnt !== 8'd4) begin errors++; $display("FAIL err_count4: got %0d want %0d", err_count, exp_cnt); end
  endtask

  task automatic test_blocked;
    logic e, ee; logic [31:0] r, er; int lat, ns, s0;
    model(1'b1, 2'd2, 13'h400, 32'h12345678, 1'b0, ee, er);
    xact(1'b1, 2'd2, 13'h400, 32'h12345678, 0, e, r, lat, ns);
    for (int k = 0; k < 3; k++) begin
      ret_en = (k == 0); pd_en = (k != 1); mbist_en = (k == 2);
      model(1'b1, 2'd2, 13'h400, 32'hAAAAAAAA, 1'b1, ee, er);
      xact(1'b1, 2'd2, 13'h400, 32'hAAAAAAAA, 0, e, r, lat, ns);
      checks++; if (e !== 1'b1 || ns != 0) begin errors++; $display("FAIL blocked%0d: err=%b strobes=%0d want 1/0", k, e, ns); end
      ret_en = 1'b0; pd_en = 1'b1; mbist_en = 1'b0;
    end
    model(1'b0, 2'd2, 13'h400, 32'h0, 1'b0, ee, er);
    xact(1'b0, 2'd2, 13'h400, 32'h0, 0, e, r, lat, ns);
    checks++; if (r !== 32'h12345678) begin errors++; $display("FAIL blocked_preserve: got %h want 12345678", r); end
    // blocking raised after acceptance must abort the access in ISSUE
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 13'h400; req_wdata = 32'hAAAAAAAA;
    s0 = strobes;
    @(posedge clk); #1;
    req_valid = 1'b0; ret_en = 1'b1;
    model(1'b1, 2'd2, 13'h400, 32'hAAAAAAAA, 1'b1, ee, er);
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || strobes != s0) begin errors++; $display("FAIL issue_block: valid=%b err=%b strobes=%0d want 1/1/0", rsp_valid, rsp_err, strobes - s0); end
    checks++; if (err_count !== exp_cnt) begin errors++; $display("FAIL issue_block_cnt: got %0d want %0d", err_count, exp_cnt); end
    ret_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    logic e, ee; logic [31:0] r, er; int lat, ns;
    rsp_ready = 1'b0;
    model(1'b0, 2'd2, 13'h400, 32'h0, 1'b0, ee, er);
    xact(1'b0, 2'd2, 13'h400, 32'h0, 0, e, r, lat, ns);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== er || req_ready !== 1'b0) begin errors++; $display("FAIL hold%0d: valid=%b rdata=%h ready=%b want 1/%h/0", k, rsp_valid, rsp_rdata, req_ready, er); end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL release: valid=%b ready=%b want 0/1", rsp_valid, req_ready); end
    model(1'b1, 2'd2, 13'h404, 32'hCAFEF00D, 1'b0, ee, er);
    xact(1'b1, 2'd2, 13'h404, 32'hCAFEF00D, 3, e, r, lat, ns);
    checks++; if (lat != 4 || ns != 4 || e !== 1'b0) begin errors++; $display("FAIL stall_write: lat=%0d strobes=%0d err=%b want 4/4/0", lat, ns, e); end
    model(1'b0, 2'd2, 13'h404, 32'h0, 1'b0, ee, er);
    xact(1'b0, 2'd2, 13'h404, 32'h0, 3, e, r, lat, ns);
    checks++; if (lat != 5 || r !== 32'hCAFEF00D) begin errors++; $display("FAIL stall_read: lat=%0d rdata=%h want 5/CAFEF00D", lat, r); end
  endtask

  task automatic test_random;
    logic e, ee, w, blk; logic [31:0] r, er, d, ew, em; logic [1:0] s; logic [12:0] a;
    logic [3:0] eb; int lat, ns, st, kind, n;
    for (int it = 0; it < 150; it++) begin
      kind = $urandom_range(0, 9);
      w = 1'($urandom); d = $urandom; st = $urandom_range(0, 2);
      s = kind == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      a = kind == 1 ? 13'(32'h1000 + $urandom_range(0, 'hFFF)) : 13'($urandom_range(0, 'h1FF));
      blk = (kind == 2);
      if (blk) case ($urandom_range(0, 2)) 0: ret_en = 1'b1; 1: pd_en = 1'b0; default: mbist_en = 1'b1; endcase
      model(w, s, a, d, blk, ee, er);
      xact(w, s, a, d, st, e, r, lat, ns);
      ret_en = 1'b0; pd_en = 1'b1; mbist_en = 1'b0;
      checks++; if (e !== ee || r !== er) begin errors++; $display("FAIL rand%0d_rsp: err=%b rdata=%h want %b/%h", it, e, r, ee, er); end
      checks++; if (lat != (ee ? 0 : (w ? 1 : 2) + st) || ns != (ee ? 0 : st + 1)) begin errors++; $display("FAIL rand%0d_timing: lat=%0d strobes=%0d", it, lat, ns); end
      checks++; if (err_count !== exp_cnt) begin errors++; $display("FAIL rand%0d_cnt: got %0d want %0d", it, err_count, exp_cnt); end
      if (!ee) begin
        n = nbytes(s); eb = 4'd0; ew = 32'd0; em = 32'd0;
        for (int i = 0; i < n; i++) begin
          eb[int'(a[1:0]) + i] = 1'b1;
          ew[8*(int'(a[1:0]) + i) +: 8] = d[8*i +: 8];
          em[8*(int'(a[1:0]) + i) +: 8] = 8'hFF;
        end
        checks++; if (mon_be !== eb || mon_addr !== {a[12:2], 2'b00}) begin errors++; $display("FAIL rand%0d_lanes: be=%b addr=%h want %b/%h", it, mon_be, mon_addr, eb, {a[12:2], 2'b00}); end
        if (w) begin
          checks++; if ((mon_wdata & em) !== ew) begin errors++; $display("FAIL rand%0d_wdata: got %h want %h", it, mon_wdata & em, ew); end
        end
      end
    end
  endtask

  task automatic test_saturate;
    logic e, ee; logic [31:0] r, er; int lat, ns;
    for (int k = 0; k < 260; k++) begin
      model(1'b0, 2'd3, 13'h0, 32'h0, 1'b0, ee, er);
      xact(1'b0, 2'd3, 13'h0, 32'h0, 0, e, r, lat, ns);
    end
    checks++; if (err_count !== 8'hFF || exp_cnt !== 8'hFF) begin errors++; $display("FAIL saturate: got %0d want 255", err_count); end
  endtask

  task automatic test_reset_capture;
    logic e, ee; logic [31:0] r, er; int lat, ns;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 13'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; exp_cnt = 8'd0;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || err_count !== 8'd0) begin errors++; $display("FAIL abort: valid=%b ready=%b cnt=%0d want 0/1/0", rsp_valid, req_ready, err_count); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_quiet: valid=%b want 0", rsp_valid); end
    model(1'b0, 2'd2, 13'h0, 32'h0, 1'b0, ee, er);
    xact(1'b0, 2'd2, 13'h0, 32'h0, 0, e, r, lat, ns);
    checks++; if (r !== er || e !== 1'b0 || lat != 2) begin errors++; $display("FAIL after_reset: rdata=%h err=%b lat=%0d want %h/0/2", r, e, lat, er); end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_word_rw;
    test_byte_lanes;
    test_errors;
    test_blocked;
    test_backpressure;
    test_random;
    test_saturate;
    test_reset_capture;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
